// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters.
// The winner's operands are registered, held on the ALU for EXEC_CYCLES cycles, and the result is captured.
module alu_arbiter #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req0,
    input  logic [3:0]  op0,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    output logic        done0,
    input  logic        req1,
    input  logic [3:0]  op1,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    output logic        done1,
    output logic [31:0] result,
    output logic        res_neg,
    output logic        res_ovf,
    output logic        res_zero,
    output logic        busy,
    output logic [3:0]  alu_aluop,
    output logic [31:0] alu_port_a,
    output logic [31:0] alu_port_b,
    input  logic [31:0] alu_outport,
    input  logic        alu_negative,
    input  logic        alu_overflow,
    input  logic        alu_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        rr_ptr_q, rr_ptr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] result_q, result_d;
    logic        neg_q, neg_d;
    logic        ovf_q, ovf_d;
    logic        zero_q, zero_d;
    logic        grant1;

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through the case can infer a latch.
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        grant1   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // Requester 1 wins when alone, or on a tie when the pointer favours it.
                    grant1  = req1 && (!req0 || rr_ptr_q);
                    owner_d = grant1;
                    op_d    = grant1 ? op1 : op0;
                    a_d     = grant1 ? a1 : a0;
                    b_d     = grant1 ? b1 : b0;
                    cnt_d   = CNT_LOAD;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    result_d = alu_outport;
                    neg_d    = alu_negative;
                    ovf_d    = alu_overflow;
                    zero_d   = alu_zero;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                rr_ptr_d = ~owner_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            rr_ptr_q <= 1'b0;
            cnt_q    <= 4'd0;
            op_q     <= 4'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            result_q <= 32'd0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign done0      = (state_q == DONE) && !owner_q;
    assign done1      = (state_q == DONE) && owner_q;
    assign busy       = (state_q != IDLE);
    assign result     = result_q;
    assign res_neg    = neg_q;
    assign res_ovf    = ovf_q;
    assign res_zero   = zero_q;
    assign alu_aluop  = op_q;
    assign alu_port_a = a_q;
    assign alu_port_b = b_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: drives two requesters against alu_arbiter with an ALU model attached, and checks
// every done pulse against a transaction-level reference model through a scoreboard queue.
module tb_alu_arbiter;

    localparam int EXEC = 3;
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;

    typedef struct {
        int          id;
        int          edge_no;
        logic [31:0] res;
        logic        neg;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        req_in [2];
    logic [3:0]  op_in  [2];
    logic [31:0] a_in   [2];
    logic [31:0] b_in   [2];
    logic        done0, done1;
    logic [1:0]  done_v;
    logic [31:0] result;
    logic        res_neg, res_ovf, res_zero, busy;
    logic [3:0]  alu_aluop;
    logic [31:0] alu_port_a, alu_port_b, alu_outport;
    logic        alu_negative, alu_overflow, alu_zero;

    int   passed = 0;
    int   total  = 0;
    int   edge_n = 0;
    int   free_edge = 0;
    int   rr_next = 0;
    exp_t sb_q [$];

    assign done_v = {done1, done0};

    alu_arbiter #(.EXEC_CYCLES(EXEC)) dut (
        .CLK(CLK), .RST(RST),
        .req0(req_in[0]), .op0(op_in[0]), .a0(a_in[0]), .b0(b_in[0]), .done0(done0),
        .req1(req_in[1]), .op1(op_in[1]), .a1(a_in[1]), .b1(b_in[1]), .done1(done1),
        .result(result), .res_neg(res_neg), .res_ovf(res_ovf), .res_zero(res_zero), .busy(busy),
        .alu_aluop(alu_aluop), .alu_port_a(alu_port_a), .alu_port_b(alu_port_b),
        .alu_outport(alu_outport), .alu_negative(alu_negative),
        .alu_overflow(alu_overflow), .alu_zero(alu_zero)
    );

    always #5 CLK = ~CLK;

    // Combinational ALU attached to the arbiter's ALU-side ports.
    always_comb begin
        alu_outport  = 32'd0;
        alu_overflow = 1'b0;
        case (alu_aluop)
            ALU_ADD: begin
                alu_outport  = alu_port_a + alu_port_b;
                alu_overflow = (alu_port_a[31] == alu_port_b[31]) && (alu_outport[31] != alu_port_a[31]);
            end
            ALU_SUB: begin
                alu_outport  = alu_port_a - alu_port_b;
                alu_overflow = (alu_port_a[31] != alu_port_b[31]) && (alu_outport[31] != alu_port_a[31]);
            end
            ALU_AND: alu_outport = alu_port_a & alu_port_b;
            ALU_OR:  alu_outport = alu_port_a | alu_port_b;
            ALU_XOR: alu_outport = alu_port_a ^ alu_port_b;
            default: alu_outport = 32'd0;
        endcase
    end
    assign alu_negative = alu_outport[31];
    assign alu_zero     = (alu_outport == 32'd0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        else
            passed++;
    endtask

    // Reference result: signed overflow judged on exact 64-bit arithmetic.
    function automatic exp_t predict(input int id, input logic [3:0] op,
                                     input logic [31:0] a, input logic [31:0] b, input int e);
        exp_t   p;
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint wide = 0;
        p.id = id;
        p.edge_no = e;
        p.ovf = 1'b0;
        case (op)
            ALU_ADD: wide = sa + sb;
            ALU_SUB: wide = sa - sb;
            default: wide = 0;
        endcase
        case (op)
            ALU_ADD, ALU_SUB: begin
                p.res = wide[31:0];
                p.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            ALU_AND: p.res = a & b;
            ALU_OR:  p.res = a | b;
            ALU_XOR: p.res = a ^ b;
            default: p.res = 32'd0;
        endcase
        p.neg  = p.res[31];
        p.zero = (p.res == 32'd0);
        return p;
    endfunction

    // Transaction model: the arbiter accepts at most one grant per EXEC+2 edges.
    initial begin : model
        int w;
        forever begin
            @(posedge CLK);
            if (RST) begin
                sb_q.delete();
                free_edge = 0;
                rr_next = 0;
            end else begin
                edge_n++;
                if (edge_n >= free_edge && (req_in[0] || req_in[1])) begin
                    w = (req_in[0] && req_in[1]) ? rr_next : (req_in[1] ? 1 : 0);
                    sb_q.push_back(predict(w, op_in[w], a_in[w], b_in[w], edge_n + EXEC));
                    free_edge = edge_n + EXEC + 2;
                    rr_next = 1 - w;
                end
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                while (sb_q.size() > 0 && sb_q[0].edge_no < edge_n) begin
                    total++;
                    $display("FAIL missed_done: no done%0d at edge %0d, expected one", sb_q[0].id, sb_q[0].edge_no);
                    void'(sb_q.pop_front());
                end
                if (done0 && done1) begin
                    total++;
                    $display("FAIL done_exclusive: done0=1 done1=1, expected at most one");
                end
                if (done0 || done1) begin
                    if (sb_q.size() == 0) begin
                        total++;
                        $display("FAIL unexpected_done: done=%b at edge %0d, expected none", done_v, edge_n);
                    end else begin
                        e = sb_q.pop_front();
                        check("done_id", 32'(done1), 32'(e.id));
                        check("done_cycle", 32'(edge_n), 32'(e.edge_no));
                        check("result", result, e.res);
                        check("res_neg", 32'(res_neg), 32'(e.neg));
                        check("res_ovf", 32'(res_ovf), 32'(e.ovf));
                        check("res_zero", 32'(res_zero), 32'(e.zero));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Call at a negedge; returns at the negedge where done is seen, with req dropped.
    task automatic do_req(input int id, input logic [3:0] op, input logic [31:0] av,
                          input logic [31:0] bv, output int lat);
        req_in[id] = 1'b1;
        op_in[id]  = op;
        a_in[id]   = av;
        b_in[id]   = bv;
        lat = 0;
        forever begin
            @(negedge CLK);
            lat++;
            if (done_v[id]) break;
            if (lat > 200) begin
                total++;
                $display("FAIL req_timeout: no done%0d after %0d cycles, expected within 200", id, lat);
                break;
            end
        end
        req_in[id] = 1'b0;
    endtask

    task automatic requester(input int id, input int n);
        int waited;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            op_in[id]  = 4'($urandom_range(0, 4));
            a_in[id]   = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
            b_in[id]   = ($urandom_range(0, 3) == 0) ? a_in[id] : $urandom;
            req_in[id] = 1'b1;
            waited = 0;
            forever begin
                @(negedge CLK);
                if (done_v[id]) break;
                waited++;
                if (waited > 100) begin
                    total++;
                    $display("FAIL rand_timeout: requester %0d waited %0d cycles, expected done within 100", id, waited);
                    break;
                end
                if ($urandom_range(0, 3) == 0) a_in[id] = $urandom;
            end
            req_in[id] = 1'b0;
        end
    endtask

    initial begin : main
        int lat, ndone, e1, e2;
        for (int i = 0; i < 2; i++) begin
            req_in[i] = 1'b0;
            op_in[i]  = 4'd0;
            a_in[i]   = 32'd0;
            b_in[i]   = 32'd0;
        end

        #3 RST = 1'b1;
        #1;
        check("rst_done", 32'(done_v), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_port_a", alu_port_a, 32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        // Both requesters held high: grants alternate starting with requester 0.
        req_in[0] = 1'b1; op_in[0] = ALU_SUB; a_in[0] = 32'd9; b_in[0] = 32'd9;
        req_in[1] = 1'b1; op_in[1] = ALU_ADD; a_in[1] = 32'd1; b_in[1] = 32'hFFFF_FFFE;
        ndone = 0;
        for (int c = 0; c < 100 && ndone < 4; c++) begin
            @(negedge CLK);
            if (done0 || done1) begin
                check("rr_order", 32'(done1), 32'(ndone % 2));
                if (done0) begin
                    check("rr_sub_result", result, 32'd0);
                    check("rr_sub_zero", 32'(res_zero), 32'd1);
                end else begin
                    check("rr_add_result", result, 32'hFFFF_FFFF);
                    check("rr_add_neg", 32'(res_neg), 32'd1);
                end
                ndone++;
            end
        end
        check("rr_count", 32'(ndone), 32'd4);
        req_in[0] = 1'b0;
        req_in[1] = 1'b0;

        // Operands held for EXEC cycles even when the requester changes them.
        @(negedge CLK);
        req_in[0] = 1'b1; op_in[0] = ALU_ADD; a_in[0] = 32'd5; b_in[0] = 32'd7;
        for (int k = 1; k <= EXEC; k++) begin
            @(negedge CLK);
            check("hold_port_a", alu_port_a, 32'd5);
            check("hold_port_b", alu_port_b, 32'd7);
            check("hold_no_done", 32'(done_v), 32'd0);
            a_in[0] = 32'hDEAD_BEEF;
            b_in[0] = 32'h1234_5678;
        end
        @(negedge CLK);
        check("add_done0", 32'(done0), 32'd1);
        check("add_done1", 32'(done1), 32'd0);
        check("add_result", result, 32'd12);
        check("add_zero", 32'(res_zero), 32'd0);
        req_in[0] = 1'b0;

        @(negedge CLK);
        do_req(1, ALU_ADD, 32'h7FFF_FFFF, 32'd1, lat);
        check("ovf_latency", 32'(lat), 32'(EXEC + 1));
        check("ovf_result", result, 32'h8000_0000);
        check("ovf_flag", 32'(res_ovf), 32'd1);
        check("ovf_neg", 32'(res_neg), 32'd1);

        // Reset during EXEC aborts the operation without a done pulse.
        @(negedge CLK);
        req_in[1] = 1'b1; op_in[1] = ALU_ADD; a_in[1] = 32'd3; b_in[1] = 32'd4;
        repeat (2) @(negedge CLK);
        #1 RST = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done_v), 32'd0);
        check("arst_result", result, 32'd0);
        check("arst_flags", 32'({res_neg, res_ovf, res_zero}), 32'd0);
        check("arst_alu", 32'(alu_aluop) | alu_port_a | alu_port_b, 32'd0);
        req_in[1] = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        ndone = 0;
        repeat (EXEC + 4) begin
            @(negedge CLK);
            if (done0 || done1) ndone++;
        end
        check("arst_no_done", 32'(ndone), 32'd0);
        check("arst_idle", 32'(busy), 32'd0);

        // Back-to-back single requester: done pulses EXEC+2 cycles apart.
        do_req(0, ALU_XOR, 32'hF0F0_F0F0, 32'hFFFF_0000, lat);
        e1 = edge_n;
        check("b2b_latency1", 32'(lat), 32'(EXEC + 1));
        @(negedge CLK);
        do_req(0, ALU_OR, 32'h0000_00F0, 32'h0000_000F, lat);
        e2 = edge_n;
        check("b2b_latency2", 32'(lat), 32'(EXEC + 1));
        check("b2b_spacing", 32'(e2 - e1), 32'(EXEC + 2));
        check("b2b_result", result, 32'h0000_00FF);

        @(negedge CLK);
        fork
            requester(0, 25);
            requester(1, 25);
        join

        repeat (EXEC + 4) @(negedge CLK);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
